// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round-iterative datapaths.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? p : 8'h00);
            p   = xtime(p);
        end
        return acc;
    endfunction

    // Byte idx of a block, FIPS-197 order: byte 0 lives in [127:120]
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
        return s[127 - 8*idx -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = get_byte(s, r + 4*((c - r + 4) % 4));
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c + 1);
            a2 = get_byte(s, 4*c + 2);
            a3 = get_byte(s, 4*c + 3);
            o[127 - 8*(4*c)     -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127 - 8*(4*c + 1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127 - 8*(4*c + 2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127 - 8*(4*c + 3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Ciphertext-in / plaintext-out handshakes plus the round-key store lookup.
interface aes_inv_cipher_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   key_idx;
    logic [127:0] key_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, out_ready, key_data,
        output in_ready, out_valid, out_data, key_idx, busy
    );

    modport master (
        output in_valid, in_data, out_ready, key_data,
        input  in_ready, out_valid, out_data, key_idx, busy
    );
endinterface

// File: rtl/inv_sub_bytes.sv
// Registered 16-byte inverse S-box stage; output valid one cycle after din.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] din,
    output logic [127:0] dout
);

    logic [127:0] sub_s;

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Byte-wise substitution
    always_comb begin
        sub_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sub_s[127 - 8*i -: 8] = inv_sbox(din[127 - 8*i -: 8]);
        end
    end

    // Pipeline register; contents only consumed in the cycle after loading
    always_ff @(posedge clk) begin
        dout <= sub_s;
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one SUB/MIX cycle pair per round.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_inv_cipher_ctrl_if.slave bus
);

    localparam logic [3:0] KEY_LAST = 4'(NR);

    fsm_state_e   fsm_r;
    fsm_state_e   fsm_s;
    logic [127:0] blk_r;
    logic [127:0] blk_s;
    logic [3:0]   round_r;
    logic [3:0]   round_s;
    logic [127:0] sbox_in_s;
    logic [127:0] sbox_out_s;
    logic [127:0] ark_s;

    assign sbox_in_s = inv_shift_rows(blk_r);

    inv_sub_bytes u_inv_sub_bytes (
        .clk  (clk),
        .din  (sbox_in_s),
        .dout (sbox_out_s)
    );

    // FSM, cipher state and round counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r   <= ST_IDLE;
            blk_r   <= 128'h0;
            round_r <= 4'd0;
        end else begin
            fsm_r   <= fsm_s;
            blk_r   <= blk_s;
            round_r <= round_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        fsm_s   = fsm_r;
        blk_s   = blk_r;
        round_s = round_r;
        ark_s   = sbox_out_s ^ bus.key_data;
        case (fsm_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    blk_s   = bus.in_data ^ bus.key_data;
                    round_s = KEY_LAST - 4'd1;
                    fsm_s   = ST_SUB;
                end else begin
                    fsm_s   = ST_IDLE;
                end
            end
            ST_SUB: begin
                fsm_s = ST_MIX;
            end
            ST_MIX: begin
                if (round_r != 4'd0) begin
                    blk_s   = inv_mix_columns(ark_s);
                    round_s = round_r - 4'd1;
                    fsm_s   = ST_SUB;
                end else begin
                    blk_s   = ark_s;
                    fsm_s   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    fsm_s = ST_IDLE;
                end else begin
                    fsm_s = ST_DONE;
                end
            end
            default: begin
                fsm_s = ST_IDLE;
            end
        endcase
    end

    // Status and key-index decode from the state register only
    always_comb begin
        bus.in_ready  = (fsm_r == ST_IDLE);
        bus.out_valid = (fsm_r == ST_DONE);
        bus.busy      = (fsm_r == ST_SUB) || (fsm_r == ST_MIX);
        case (fsm_r)
            ST_IDLE: bus.key_idx = KEY_LAST;
            ST_SUB:  bus.key_idx = round_r;
            ST_MIX:  bus.key_idx = round_r;
            ST_DONE: bus.key_idx = 4'd0;
            default: bus.key_idx = KEY_LAST;
        endcase
    end

    assign bus.out_data = blk_r;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench: forward-AES reference model produces ciphertexts, DUT must recover plaintext.
module tb_aes_inv_cipher_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_cipher_ctrl_if bus ();

    aes_inv_cipher_ctrl #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [11];

    // Key store: combinational lookup
    always_comb bus.key_data = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : 128'h0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           stall;
        bit           garbage;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        logic [7:0] x;
        logic [7:0] y;
        res = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) res = res ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return res;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Forward S-box by brute-force inverse search plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (t_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = t_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r + 4*c] = tmp[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = t_mul(a0, 8'h02) ^ t_mul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ t_mul(a1, 8'h02) ^ t_mul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ t_mul(a2, 8'h02) ^ t_mul(a3, 8'h03);
                    st[4*c+3] = t_mul(a0, 8'h03) ^ a1 ^ a2 ^ t_mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic accept_block(input logic [127:0] ct);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_ready", 128'(bus.in_ready), 128'd1);
        chk("accept_key_idx", 128'(bus.key_idx), 128'd10);
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
    endtask

    task automatic finish_block(input logic [127:0] exp, input int stall, input bit garbage, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            chk({name, "_busy"}, 128'(bus.busy), 128'd1);
            chk({name, "_in_ready_low"}, 128'(bus.in_ready), 128'd0);
            if (n <= 20) chk({name, "_key_idx"}, 128'(bus.key_idx), 128'(9 - (n - 1) / 2));
            bus.in_valid = garbage;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        chk({name, "_out_valid_seen"}, 128'(seen), 128'd1);
        chk({name, "_latency"}, 128'(n), 128'd21);
        chk({name, "_data"}, bus.out_data, exp);
        chk({name, "_done_key_idx"}, 128'(bus.key_idx), 128'd0);
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = s[0];
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk({name, "_stall_valid"}, 128'(bus.out_valid), 128'd1);
            chk({name, "_stall_in_ready"}, 128'(bus.in_ready), 128'd0);
            chk({name, "_stall_data"}, bus.out_data, exp);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_release_idle"}, 128'(bus.in_ready), 128'd1);
        chk({name, "_release_valid"}, 128'(bus.out_valid), 128'd0);
    endtask

    initial begin
        int acc[$];
        int dn[$];
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;

        bus.in_valid  = 1'b0;
        bus.in_data   = 128'h0;
        bus.out_ready = 1'b0;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt: 128'h00112233445566778899aabbccddeeff, stall: 0, garbage: 1'b0};
        vecs[1] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt: 128'h0, stall: 0, garbage: 1'b0};
        vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                    pt: 128'h3243f6a8885a308d313198a2e0370734, stall: 15, garbage: 1'b1};
        vecs[3] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt: 128'h00112233445566778899aabbccddeeff, stall: 3, garbage: 1'b1};

        build_sbox();
        expand_key(vecs[0].key);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_out_data", bus.out_data, 128'h0);
        chk("rst_key_idx", 128'(bus.key_idx), 128'd10);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            expand_key(vecs[i].key);
            chk($sformatf("model_vec%0d", i), encrypt(vecs[i].pt), vecs[i].ct);
            accept_block(vecs[i].ct);
            finish_block(vecs[i].pt, vecs[i].stall, vecs[i].garbage, $sformatf("vec%0d", i));
        end

        // Back-to-back with in_valid and out_ready held high
        expand_key(vecs[0].key);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = vecs[0].ct;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (bus.in_ready) acc.push_back(k);
            if (bus.out_valid) begin
                dn.push_back(k);
                chk("b2b_data", bus.out_data, vecs[0].pt);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_accept_count", 128'(acc.size() >= 2), 128'd1);
        chk("b2b_done_count", 128'(dn.size() >= 2), 128'd1);
        if (acc.size() >= 2 && dn.size() >= 1) begin
            chk("b2b_accept_spacing", 128'(acc[1] - acc[0]), 128'd22);
            chk("b2b_latency", 128'(dn[0] - acc[0]), 128'd21);
        end
        begin
            int w;
            w = 0;
            while (!bus.out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("b2b_drain_valid", 128'(bus.out_valid), 128'd1);
            chk("b2b_drain_data", bus.out_data, vecs[0].pt);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end

        // Reset in the middle of round processing
        accept_block(vecs[0].ct);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_key_idx", 128'(bus.key_idx), 128'd10);
        chk("midrst_out_data", bus.out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        accept_block(vecs[0].ct);
        finish_block(vecs[0].pt, 0, 1'b0, "post_rst");

        // Randomized blocks against the forward-cipher model
        for (int r = 0; r < 6; r++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            ct = encrypt(pt);
            accept_block(ct);
            finish_block(pt, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
